// File: rtl/s27_seq_core.sv
// s27 sequential closure: three state flops around the s27 next-state logic,
// with a serial scan chain and a saturating step counter.
module s27_seq_core #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pi0,
  input  logic             pi1,
  input  logic             pi2,
  input  logic             pi3,
  input  logic             en,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             po0,
  output logic [2:0]       state,
  output logic             scan_out,
  output logic [CNT_W-1:0] step_cnt
);
  typedef struct packed {
    logic s6;
    logic s5;
    logic s4;
  } s27_st_t;

  s27_st_t          st_q, st_d, nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a, b, c, d;
  logic             x19, x22;

  assign a = pi0;
  assign b = pi1;
  assign c = pi2;
  assign d = pi3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    nxt    = '0;
    nxt.s4 = a & ~(~st_q.s6 & d & ~st_q.s4 & ~b);
    nxt.s5 = ~st_q.s4 & ((d & ((~a & st_q.s5 & (st_q.s6 | b)) | (~b & ~st_q.s6)))
                         | (~a & ~d & st_q.s5));
    nxt.s6 = ~c & (st_q.s6 | b);

    st_d  = st_q;
    cnt_d = cnt_q;
    // Scan shifts toward s6 so scan_out drains s6, s5, s4 in order.
    if (scan_en) begin
      st_d = '{s6: st_q.s5, s5: st_q.s4, s4: scan_in};
    end else if (en) begin
      st_d  = nxt;
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    x19      = ~st_q.s4 & ((a & st_q.s5 & (st_q.s6 | b)) | (b & ~st_q.s5 & ~st_q.s6));
    x22      = st_q.s4 & (st_q.s5 | ~st_q.s6);
    po0      = (d & (x19 | x22))
             | (~d & ((~st_q.s5 & ~st_q.s6) | (st_q.s5 & (st_q.s4 | a))))
             | (~st_q.s5 & st_q.s6);
    state    = st_q;
    scan_out = st_q.s6;
    step_cnt = cnt_q;
  end
endmodule

// File: tb/tb_s27_seq_core.sv
// Bench for s27_seq_core: constant vector table, hand sequences for scan,
// saturation and async reset, then random stimulus against an equation model.
module tb_s27_seq_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pi0 = 0, pi1 = 0, pi2 = 0, pi3 = 0, en = 0, scan_en = 0, scan_in = 0;
  logic       po0, scan_out, po0_2, scan_out_2;
  logic [2:0] state, state_2;
  logic [7:0] step_cnt;
  logic [1:0] step_cnt_2;

  int checks = 0;
  int failures = 0;

  bit [2:0] m_s;
  int       m_c8, m_c2;

  always #5 clk = ~clk;

  s27_seq_core #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .pi0(pi0), .pi1(pi1), .pi2(pi2), .pi3(pi3),
    .en(en), .scan_en(scan_en), .scan_in(scan_in),
    .po0(po0), .state(state), .scan_out(scan_out), .step_cnt(step_cnt));

  s27_seq_core #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .pi0(pi0), .pi1(pi1), .pi2(pi2), .pi3(pi3),
    .en(en), .scan_en(scan_en), .scan_in(scan_in),
    .po0(po0_2), .state(state_2), .scan_out(scan_out_2), .step_cnt(step_cnt_2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model straight from the s27 equations; s = {s6,s5,s4}.
  function automatic bit m_po(bit a, bit b, bit d, bit [2:0] s);
    bit s4 = s[0], s5 = s[1], s6 = s[2];
    bit x19 = !s4 && ((a && s5 && (s6 || b)) || (b && !s5 && !s6));
    bit x22 = s4 && (s5 || !s6);
    return (d && (x19 || x22)) || (!d && ((!s5 && !s6) || (s5 && (s4 || a)))) || (!s5 && s6);
  endfunction

  function automatic bit [2:0] m_nxt(bit a, bit b, bit c, bit d, bit [2:0] s);
    bit s4 = s[0], s5 = s[1], s6 = s[2];
    bit n4 = a && !(!s6 && d && !s4 && !b);
    bit n5 = !s4 && ((d && ((!a && s5 && (s6 || b)) || (!b && !s6))) || (!a && !d && s5));
    bit n6 = !c && (s6 || b);
    return {n6, n5, n4};
  endfunction

  // One cycle: drive at posedge+1, check combinational outputs, take the edge,
  // advance the model and check registered outputs.
  task automatic tick(input bit a, b, c, d, e, se, si);
    pi0 = a; pi1 = b; pi2 = c; pi3 = d; en = e; scan_en = se; scan_in = si;
    #1;
    chk("po0", po0, m_po(a, b, d, m_s));
    chk("po0_w2", po0_2, m_po(a, b, d, m_s));
    chk("scan_out", scan_out, m_s[2]);
    @(posedge clk); #1;
    if (se) m_s = {m_s[1:0], si};
    else if (e) begin
      m_s  = m_nxt(a, b, c, d, m_s);
      m_c8 = (m_c8 == 255) ? 255 : m_c8 + 1;
      m_c2 = (m_c2 == 3) ? 3 : m_c2 + 1;
    end
    chk("state", state, m_s);
    chk("state_w2", state_2, m_s);
    chk("step_cnt", step_cnt, m_c8);
    chk("step_cnt_w2", step_cnt_2, m_c2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_s = '0; m_c8 = 0; m_c2 = 0;
  endtask

  typedef struct {
    bit       a, b, c, d, en;
    bit       exp_po;
    bit [2:0] exp_state;
    int       exp_cnt;
  } vec_t;

  vec_t vt[10];
  bit   so_seq[3];
  int   c2_seq[5];

  initial begin
    vt[0] = '{0,0,0,0,1, 1, 3'b000, 1};
    vt[1] = '{0,0,0,0,1, 1, 3'b000, 2};
    vt[2] = '{0,0,0,0,1, 1, 3'b000, 3};
    vt[3] = '{0,0,0,0,1, 1, 3'b000, 4};
    vt[4] = '{0,1,0,0,1, 1, 3'b100, 5};
    vt[5] = '{0,0,0,0,1, 1, 3'b100, 6};
    vt[6] = '{0,0,1,0,1, 1, 3'b000, 7};
    vt[7] = '{1,0,0,0,1, 1, 3'b001, 8};
    vt[8] = '{0,0,0,1,0, 1, 3'b001, 8};
    vt[9] = '{1,0,0,1,1, 1, 3'b001, 9};
    so_seq = '{1'b1, 1'b0, 1'b1};
    c2_seq = '{1, 2, 3, 3, 3};
    m_s = '0; m_c8 = 0; m_c2 = 0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_state", state, 3'b000);
    chk("reset_cnt", step_cnt, 0);
    chk("reset_scan_out", scan_out, 0);
    #1 chk("reset_po0_d0", po0, 1);
    pi3 = 1'b1;
    #1 chk("reset_po0_d1", po0, 0);

    for (int i = 0; i < 10; i++) begin
      pi0 = vt[i].a; pi1 = vt[i].b; pi2 = vt[i].c; pi3 = vt[i].d; en = vt[i].en;
      #1 chk("tbl_po0", po0, vt[i].exp_po);
      tick(vt[i].a, vt[i].b, vt[i].c, vt[i].d, vt[i].en, 0, 0);
      chk("tbl_state", state, vt[i].exp_state);
      chk("tbl_cnt", step_cnt, vt[i].exp_cnt);
    end

    // From reset with a=d=1 the equations set only s5.
    do_reset();
    tick(1, 0, 0, 1, 1, 0, 0);
    chk("ad_state", state, 3'b010);

    for (int rep = 0; rep < 2; rep++) begin
      do_reset();
      tick(0, 0, 0, 0, 1, 0, 0);
      tick(1, 0, 0, 1, 0, 1, 1);
      tick(0, 1, 0, 0, rep[0], 1, 0);
      tick(0, 0, 0, 0, rep[0], 1, 1);
      chk("scan_load", state, 3'b101);
      chk("scan_cnt", step_cnt, 1);
      for (int i = 0; i < 3; i++) begin
        en = rep[0]; scan_en = 1; scan_in = 0;
        #1 chk("scan_unload", scan_out, so_seq[i]);
        tick(0, 0, 0, 0, rep[0], 1, 0);
      end
      chk("scan_empty", state, 3'b000);
      chk("scan_cnt2", step_cnt, 1);
    end

    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1, 0, 0);
      chk("sat_w2", step_cnt_2, c2_seq[i]);
    end

    tick(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 1, 1);
    chk("load111", state, 3'b111);
    #2 rst = 1'b1;
    #1;
    chk("async_state", state, 3'b000);
    chk("async_cnt", step_cnt, 0);
    chk("async_scan_out", scan_out, 0);
    #1 rst = 1'b0;
    m_s = '0; m_c8 = 0; m_c2 = 0;
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_hold", state, 3'b000);

    for (int i = 0; i < 900; i++) begin
      tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 2), 1'($urandom));
    end
    chk("rand_sat", step_cnt, m_c8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
